// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: controller states,
// default widths and the PC value loaded by reset.
package fetch_pkg;

    localparam int PC_W_DEF  = 8;
    localparam int CNT_W_DEF = 16;
    localparam int RESET_PC  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Candidate next-PC values for the fetch unit: sequential, absolute branch
// and PC-relative branch, all wrapping modulo 2^PC_W.
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] pc_inc,
    output logic [PC_W-1:0] pc_abs,
    output logic [PC_W-1:0] pc_rel
);

    // The offset is already PC_W wide, so a same-width add is exactly
    // PC + sign-extended offset with the carry dropped.
    assign pc_inc = pc + PC_W'(1);
    assign pc_abs = branch_target;
    assign pc_rel = pc + branch_target;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch controller: IDLE/RUN/DONE sequencing, PC register with
// prioritised next-PC selection and a saturating run-cycle counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddress,
    input  logic             Halt,
    input  logic             Stall,
    input  logic             BranchEn,
    input  logic             BranchRel,
    input  logic [PC_W-1:0]  BranchTarget,
    output logic [PC_W-1:0]  PC,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount
);

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [PC_W-1:0]  pc_next;
    logic [CNT_W-1:0] count_next;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  pc_abs;
    logic [PC_W-1:0]  pc_rel;

    next_pc_calc #(
        .PC_W (PC_W)
    ) u_next_pc_calc (
        .pc            (PC),
        .branch_target (BranchTarget),
        .pc_inc        (pc_inc),
        .pc_abs        (pc_abs),
        .pc_rel        (pc_rel)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= IDLE;
            PC         <= PC_W'(RESET_PC);
            CycleCount <= '0;
        end else begin
            state      <= state_next;
            PC         <= pc_next;
            CycleCount <= count_next;
        end
    end

    // Start wins from any state; in RUN every cycle (stall and halt included)
    // is counted before the Halt > Stall > BranchEn > increment selection.
    always_comb begin
        state_next = state;
        pc_next    = PC;
        count_next = CycleCount;
        if (Start) begin
            state_next = RUN;
            pc_next    = StartAddress;
            count_next = '0;
        end else begin
            case (state)
                RUN: begin
                    if (CycleCount != {CNT_W{1'b1}}) begin
                        count_next = CycleCount + CNT_W'(1);
                    end
                    if (Halt) begin
                        state_next = DONE;
                    end else if (Stall) begin
                        pc_next = PC;
                    end else if (BranchEn) begin
                        pc_next = BranchRel ? pc_rel : pc_abs;
                    end else begin
                        pc_next = pc_inc;
                    end
                end
                IDLE:    state_next = IDLE;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign Running = (state == RUN);
    assign Done    = (state == DONE);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table for sequencing and
// branch behaviour, plus a narrow-counter instance for saturation.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic [7:0]  StartAddress;
    logic        Halt;
    logic        Stall;
    logic        BranchEn;
    logic        BranchRel;
    logic [7:0]  BranchTarget;
    logic [7:0]  PC;
    logic        Running;
    logic        Done;
    logic [15:0] CycleCount;
    logic [7:0]  pc_small;
    logic        running_small;
    logic        done_small;
    logic [3:0]  count_small;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        reset;
        logic        start;
        logic [7:0]  start_addr;
        logic        halt;
        logic        stall;
        logic        br_en;
        logic        br_rel;
        logic [7:0]  br_tgt;
        logic [7:0]  exp_pc;
        logic        exp_running;
        logic        exp_done;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vecs[$];

    always #5 CLK = ~CLK;

    fetch_unit #(
        .PC_W  (8),
        .CNT_W (16)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .Start        (Start),
        .StartAddress (StartAddress),
        .Halt         (Halt),
        .Stall        (Stall),
        .BranchEn     (BranchEn),
        .BranchRel    (BranchRel),
        .BranchTarget (BranchTarget),
        .PC           (PC),
        .Running      (Running),
        .Done         (Done),
        .CycleCount   (CycleCount)
    );

    fetch_unit #(
        .PC_W  (8),
        .CNT_W (4)
    ) dut_small (
        .CLK          (CLK),
        .Reset        (Reset),
        .Start        (Start),
        .StartAddress (StartAddress),
        .Halt         (Halt),
        .Stall        (Stall),
        .BranchEn     (BranchEn),
        .BranchRel    (BranchRel),
        .BranchTarget (BranchTarget),
        .PC           (pc_small),
        .Running      (running_small),
        .Done         (done_small),
        .CycleCount   (count_small)
    );

    function automatic void add_vec(
        input logic rst, input logic st, input logic [7:0] sa,
        input logic hl, input logic sl, input logic be, input logic br,
        input logic [7:0] bt, input logic [7:0] epc, input logic erun,
        input logic edone, input logic [15:0] ecnt);
        vec_t v;
        v.reset = rst; v.start = st; v.start_addr = sa;
        v.halt = hl; v.stall = sl; v.br_en = be; v.br_rel = br; v.br_tgt = bt;
        v.exp_pc = epc; v.exp_running = erun; v.exp_done = edone;
        v.exp_count = ecnt;
        vecs.push_back(v);
    endfunction

    // Inputs change on the falling edge so they are stable at the rising edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge CLK);
        Reset        = v.reset;
        Start        = v.start;
        StartAddress = v.start_addr;
        Halt         = v.halt;
        Stall        = v.stall;
        BranchEn     = v.br_en;
        BranchRel    = v.br_rel;
        BranchTarget = v.br_tgt;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string label, input int idx,
                               input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s step %0d: got 0x%0h, expected 0x%0h",
                     label, idx, actual, expected);
        end
    endtask

    initial begin
        vec_t v;
        Reset = 1'b0; Start = 1'b0; StartAddress = '0; Halt = 1'b0;
        Stall = 1'b0; BranchEn = 1'b0; BranchRel = 1'b0; BranchTarget = '0;

        //       rst st  addr  hl sl be br tgt    pc    run dn count
        add_vec(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 16'd0);
        add_vec(0, 0, 8'h00, 1, 1, 1, 0, 8'h44, 8'h00, 0, 0, 16'd0);
        add_vec(0, 1, 8'h10, 0, 0, 0, 0, 8'h00, 8'h10, 1, 0, 16'd0);
        add_vec(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h11, 1, 0, 16'd1);
        add_vec(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h12, 1, 0, 16'd2);
        add_vec(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h13, 1, 0, 16'd3);
        add_vec(0, 1, 8'h20, 0, 0, 0, 0, 8'h00, 8'h20, 1, 0, 16'd0);
        add_vec(0, 0, 8'h00, 0, 0, 1, 1, 8'hFC, 8'h1C, 1, 0, 16'd1);
        add_vec(0, 0, 8'h00, 0, 0, 1, 0, 8'h80, 8'h80, 1, 0, 16'd2);
        add_vec(0, 1, 8'hFF, 0, 0, 0, 0, 8'h00, 8'hFF, 1, 0, 16'd0);
        add_vec(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 16'd1);
        add_vec(0, 1, 8'hFE, 0, 0, 0, 0, 8'h00, 8'hFE, 1, 0, 16'd0);
        add_vec(0, 0, 8'h00, 0, 0, 1, 1, 8'h05, 8'h03, 1, 0, 16'd1);
        add_vec(0, 1, 8'h30, 0, 0, 0, 0, 8'h00, 8'h30, 1, 0, 16'd0);
        add_vec(0, 0, 8'h00, 0, 1, 1, 0, 8'h90, 8'h30, 1, 0, 16'd1);
        add_vec(0, 0, 8'h00, 0, 1, 1, 1, 8'h55, 8'h30, 1, 0, 16'd2);
        add_vec(0, 0, 8'h00, 1, 1, 1, 0, 8'hAA, 8'h30, 0, 1, 16'd3);
        add_vec(0, 0, 8'h00, 1, 1, 1, 0, 8'h66, 8'h30, 0, 1, 16'd3);
        add_vec(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h30, 0, 1, 16'd3);
        add_vec(0, 1, 8'h40, 0, 0, 0, 0, 8'h00, 8'h40, 1, 0, 16'd0);
        add_vec(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h41, 1, 0, 16'd1);
        add_vec(0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 8'h41, 0, 1, 16'd2);
        add_vec(1, 1, 8'h77, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 16'd0);
        add_vec(0, 1, 8'h50, 0, 0, 0, 0, 8'h00, 8'h50, 1, 0, 16'd0);
        add_vec(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h51, 1, 0, 16'd1);
        add_vec(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 16'd0);
        add_vec(0, 0, 8'h00, 1, 1, 1, 0, 8'h12, 8'h00, 0, 0, 16'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            applyStimulus(v);
            checkOutput("pc",      i, 32'(PC),         32'(v.exp_pc));
            checkOutput("running", i, 32'(Running),    32'(v.exp_running));
            checkOutput("done",    i, 32'(Done),       32'(v.exp_done));
            checkOutput("count",   i, 32'(CycleCount), 32'(v.exp_count));
        end

        // Counter saturation on a 4-bit counter instance: after k RUN cycles
        // the count must be min(k, 15); stalls still count.
        v = '{reset: 1'b1, start: 1'b0, start_addr: 8'h00, halt: 1'b0,
              stall: 1'b0, br_en: 1'b0, br_rel: 1'b0, br_tgt: 8'h00,
              exp_pc: 8'h00, exp_running: 1'b0, exp_done: 1'b0,
              exp_count: 16'd0};
        applyStimulus(v);
        v.reset = 1'b0;
        v.start = 1'b1;
        v.start_addr = 8'h08;
        applyStimulus(v);
        checkOutput("sat_start", 0, 32'(count_small), 32'd0);
        v.start = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            v.stall = (k % 5 == 0);
            applyStimulus(v);
            checkOutput("sat_count", k, 32'(count_small),
                        32'((k > 15) ? 15 : k));
            checkOutput("sat_wide", k, 32'(CycleCount), 32'(k));
        end
        checkOutput("sat_running", 18, 32'(running_small), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 8, program-counter width; it matches the 256-deep instruction ROM address.
REQ-002 Parameter CNT_W, default 16, cycle-counter width.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  single-cycle pulse that begins or restarts program execution.
REQ-006 StartAddress  input  PC_W  PC value loaded on Start.
REQ-007 Halt  input  1  from decoder; current instruction is the program's last.
REQ-008 Stall  input  1  hold PC this cycle.
REQ-009 BranchEn  input  1  taken branch this cycle.
REQ-010 BranchRel  input  1  1 = BranchTarget is a signed two's-complement offset; 0 = BranchTarget is an absolute address.
REQ-011 BranchTarget  input  PC_W  branch target or offset.
REQ-012 PC  output  PC_W  registered instruction address that drives the instruction ROM address input.
REQ-013 Running  output  1  high while in RUN.
REQ-014 Done  output  1  high, as a level, while in DONE.
REQ-015 CycleCount  output  CNT_W  number of cycles spent in RUN since the last Start.

Function
REQ-016 Three states: IDLE, RUN and DONE.
REQ-017 IDLE: PC is held; Start moves the block to RUN, loads PC <= StartAddress and clears CycleCount.
REQ-018 RUN: the next PC is selected in priority order Start > Halt > Stall > BranchEn > increment.
REQ-019 Start in RUN or DONE has the same effect as in IDLE (reload PC, clear CycleCount, enter RUN).
REQ-020 Halt in RUN moves the block to DONE with PC held; Stall, BranchEn and BranchRel are ignored that cycle.
REQ-021 Stall in RUN holds PC; BranchEn is ignored that cycle.
REQ-022 Absolute branch: PC <= BranchTarget.
REQ-023 Relative branch: PC <= PC + sign-extended BranchTarget, modulo 2^PC_W.
REQ-024 Increment: PC <= PC + 1, modulo 2^PC_W; 255 wraps to 0 with no error flag.
REQ-025 Latency: every PC update becomes visible on the cycle after the qualifying input is sampled; the instruction at PC is available combinationally in the same cycle.
REQ-026 CycleCount increments by 1 on every cycle spent in RUN, including stall cycles and the Halt cycle.
REQ-027 CycleCount saturates at 2^CNT_W-1.
REQ-028 CycleCount is held in IDLE and DONE.
REQ-029 DONE: PC and CycleCount are held; all inputs except Start and Reset are ignored.
REQ-030 Halt, Stall and BranchEn asserted in IDLE have no effect.
REQ-031 Running and Done are decoded from the registered state and are never high together.

Reset
REQ-032 Reset outranks every other input, including Start in the same cycle.
REQ-033 Reset forces state to IDLE, PC to 0, CycleCount to 0, Running to 0 and Done to 0 on the next rising edge.
REQ-034 Reset asserted mid-RUN abandons the program; no Done pulse is produced.

Structure
REQ-035 Shared package fetch_pkg holds: the state enum (IDLE, RUN, DONE), PC_W and CNT_W defaults, and the reset PC constant (0).
REQ-036 One combinational sub-module, next_pc_calc, computes the increment, absolute and relative candidate PCs with modulo wrap; fetch_unit holds the state register, PC register, counter and priority mux.

Verification
REQ-037 Reset, Start with StartAddress=0x10, no other inputs for 3 cycles -> PC sequence 0x10, 0x11, 0x12; Running=1; CycleCount=3.
REQ-038 In RUN at PC=0x20: BranchEn=1, BranchRel=1, BranchTarget=0xFC -> next PC=0x1C; then BranchRel=0, BranchTarget=0x80 -> next PC=0x80.
REQ-039 In RUN at PC=0xFF, no branch -> next PC=0x00; at PC=0xFE, relative offset 0x05 -> next PC=0x03.
REQ-040 In RUN at PC=0x30: Stall=1 and BranchEn=1 together for 2 cycles -> PC stays 0x30 and CycleCount rises by 2; Halt and BranchEn together -> DONE, PC=0x30, Done=1, Running=0.
REQ-041 In DONE, Start with StartAddress=0x40 -> RUN, PC=0x40, CycleCount=0; Reset and Start in the same cycle -> IDLE, PC=0.
REQ-042 Force CycleCount to 0xFFFE in RUN and run 3 cycles -> CycleCount stays at 0xFFFF.
